usb_packet_rx: RTL and testbench



---
 rtl/usb_packet_rx_pkg.sv | 41 ++++
 rtl/usb_crc.sv | 43 ++++
 rtl/usb_packet_rx.sv | 203 ++++++++++++++++++++
 tb/tb_usb_packet_rx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_packet_rx_pkg.sv
// Shared types and constants for the USB packet-layer receiver.
// PID encodings, CRC polynomials/residuals, FSM states and PID classification.
package usb_packet_rx_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_IN    = 4'h9,
    PID_SOF   = 4'h5,
    PID_SETUP = 4'hD,
    PID_DATA0 = 4'h3,
    PID_DATA1 = 4'hB,
    PID_ACK   = 4'h2,
    PID_NAK   = 4'hA,
    PID_STALL = 4'hE
  } pid_t;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_RESID  = 5'h0C;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_DRAIN
  } state_t;

  // Unknown PIDs fall through to DRAIN; the caller flags pid_err.
  function automatic state_t pid_next(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: return ST_TOKEN;
      PID_DATA0, PID_DATA1:                return ST_DATA;
      PID_ACK, PID_NAK, PID_STALL:         return ST_HSHK;
      default:                             return ST_DRAIN;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc.sv
// Byte-wide CRC register, bits consumed LSB first as they appear on the wire.
// Initialises to all-ones on reset or clr; en folds in one byte.
module usb_crc #(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = 16'h8005
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   data,
  output logic [W-1:0] crc
);

  logic [W-1:0] crc_q;
  logic [W-1:0] crc_d;

  function automatic logic [W-1:0] crc_byte(input logic [W-1:0] c_in, input logic [7:0] d);
    logic [W-1:0] c;
    logic         fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[W-1] ^ d[i];
      c  = {c[W-2:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = '1;
    else if (en) crc_d = crc_byte(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= '1;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_packet_rx.sv
// USB packet-layer receiver: PID check, token/SOF decode, CRC5/CRC16 check,
// payload forwarding with CRC bytes stripped, and a one-cycle end-of-packet status.
module usb_packet_rx
  import usb_packet_rx_pkg::*;
#(
  parameter int MAX_DATA = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [10:0] frame,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        done,
  output logic        ok,
  output logic [3:0]  err
);

  localparam int               CNT_W     = $clog2(MAX_DATA + 5);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_DATA + 4);
  localparam logic [CNT_W-1:0] LEN_LIMIT = CNT_W'(MAX_DATA + 3);
  localparam logic [CNT_W-1:0] CNT_TOK   = CNT_W'(3);

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       acc_err_q, acc_err_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]       hcnt_q, hcnt_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [10:0]      frame_q, frame_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [3:0]       err_q, err_d;
  logic [3:0]       eop_err;
  logic [4:0]       crc5;
  logic [15:0]      crc16;
  logic             byte_in;

  assign byte_in = rx_active && rx_valid && !rx_error;

  usb_crc #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
    .clk(clk), .reset(reset), .clr(state_q == ST_IDLE),
    .en(byte_in && state_q == ST_TOKEN), .data(rx_data), .crc(crc5)
  );

  usb_crc #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk(clk), .reset(reset), .clr(state_q == ST_IDLE),
    .en(byte_in && state_q == ST_DATA), .data(rx_data), .crc(crc16)
  );

  // Checks that can only be judged once the whole packet has been seen.
  always_comb begin
    eop_err = acc_err_q;
    case (state_q)
      ST_PID: eop_err[0] = 1'b1;
      ST_TOKEN: begin
        if (cnt_q != CNT_TOK)    eop_err[2] = 1'b1;
        if (crc5 != CRC5_RESID)  eop_err[1] = 1'b1;
      end
      ST_DATA: begin
        if (cnt_q < CNT_TOK)     eop_err[2] = 1'b1;
        if (crc16 != CRC16_RESID) eop_err[1] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    active_d    = rx_active;
    cnt_d       = cnt_q;
    acc_err_d   = acc_err_q;
    byte1_d     = byte1_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    hcnt_d      = hcnt_q;
    pid_d       = pid_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    frame_d     = frame_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    err_d       = 4'h0;
    if (state_q == ST_IDLE) begin
      // Only a genuine rising edge starts a packet, so one in flight at reset release is skipped.
      if (rx_active && !active_q) begin
        state_d   = ST_PID;
        cnt_d     = '0;
        acc_err_d = 4'h0;
        hcnt_d    = 2'd0;
      end
    end else if (!rx_active) begin
      done_d  = 1'b1;
      err_d   = eop_err;
      ok_d    = (eop_err == 4'h0);
      state_d = ST_IDLE;
    end else if (rx_error) begin
      acc_err_d[3] = 1'b1;
      state_d      = ST_DRAIN;
    end else if (rx_valid) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
        ST_PID: begin
          pid_d   = rx_data[3:0];
          state_d = pid_next(rx_data[3:0]);
          if (rx_data[7:4] != ~rx_data[3:0] || state_d == ST_DRAIN) begin
            acc_err_d[0] = 1'b1;
            state_d      = ST_DRAIN;
          end
        end
        ST_TOKEN: begin
          if (cnt_q == CNT_W'(1)) byte1_d = rx_data;
          if (cnt_q == CNT_W'(2)) begin
            addr_d  = byte1_q[6:0];
            endp_d  = {rx_data[2:0], byte1_q[7]};
            frame_d = {rx_data[2:0], byte1_q};
          end
        end
        ST_DATA: begin
          if (cnt_q == LEN_LIMIT) begin
            acc_err_d[2] = 1'b1;
            state_d      = ST_DRAIN;
          end else if (hcnt_q == 2'd2) begin
            out_data_d  = hold0_q;
            out_valid_d = 1'b1;
            hold0_d     = hold1_q;
            hold1_d     = rx_data;
          end else if (hcnt_q == 2'd1) begin
            hold1_d = rx_data;
            hcnt_d  = 2'd2;
          end else begin
            hold0_d = rx_data;
            hcnt_d  = 2'd1;
          end
        end
        ST_HSHK: acc_err_d[2] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b1;
      cnt_q       <= '0;
      acc_err_q   <= 4'h0;
      hcnt_q      <= 2'd0;
      pid_q       <= 4'h0;
      addr_q      <= 7'h0;
      endp_q      <= 4'h0;
      frame_q     <= 11'h0;
      out_data_q  <= 8'h0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      acc_err_q   <= acc_err_d;
      hcnt_q      <= hcnt_d;
      pid_q       <= pid_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      frame_q     <= frame_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
    byte1_q <= byte1_d;
    hold0_q <= hold0_d;
    hold1_q <= hold1_d;
  end

  assign pid       = pid_q;
  assign addr      = addr_q;
  assign endp      = endp_q;
  assign frame     = frame_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign ok        = ok_q;
  assign err       = err_q;

endmodule

// File: tb/tb_usb_packet_rx.sv
// Bench for usb_packet_rx: table of whole packets plus hand-written corner sequences,
// with payload bytes and end-of-packet status checked through scoreboard queues.
module tb_usb_packet_rx;

  localparam int MAXD = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_active, rx_valid, rx_error;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frame;
  logic [7:0]  out_data;
  logic        out_valid, done, ok;
  logic [3:0]  err;

  always #5 clk = ~clk;

  usb_packet_rx #(.MAX_DATA(MAXD)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_active(rx_active),
    .rx_valid(rx_valid), .rx_error(rx_error), .pid(pid), .addr(addr),
    .endp(endp), .frame(frame), .out_data(out_data), .out_valid(out_valid),
    .done(done), .ok(ok), .err(err)
  );

  typedef struct packed {
    logic [63:0] bytes;   // byte i at [i*8 +: 8]
    logic [3:0]  nb;
    logic        add_crc;
    logic        flip;
    logic [3:0]  pid;
    logic [3:0]  err;
    logic [3:0]  nout;
    logic        tok;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } vec_t;

  typedef struct packed {
    logic [3:0]  pid;
    logic [3:0]  err;
    logic [3:0]  mask;
    logic        ok;
    logic        tok;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] frame;
  } stat_t;

  stat_t      st_q[$];
  logic [7:0] pay_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  bit         skip_pay = 1'b0;
  logic [7:0] pk[0:79];
  int         pk_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [15:0] crc16_bytes(input int first, input int last);
    logic [15:0] c;
    logic        fb;
    logic [7:0]  r0, r1;
    c = 16'hFFFF;
    for (int k = first; k <= last; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ pk[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    for (int i = 0; i < 8; i++) begin
      r0[i] = ~c[15-i];
      r1[i] = ~c[7-i];
    end
    return {r0, r1};
  endfunction

  // Second token byte: the 3 high field bits, then the inverted CRC5 sent MSB first.
  function automatic logic [7:0] tok_b2(input logic [7:0] b1, input logic [2:0] hi);
    logic [4:0]  c;
    logic [10:0] v;
    logic        fb;
    logic [7:0]  r;
    c = 5'h1F;
    v = {hi, b1};
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ v[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'h05;
    end
    r[2:0] = hi;
    for (int j = 0; j < 5; j++) r[3+j] = ~c[4-j];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !skip_pay) begin
        if (pay_q.size() == 0) fail_now("unexpected out_valid", "payload strobe with none required");
        else check("payload byte", {56'd0, out_data}, {56'd0, pay_q.pop_front()});
      end
      if (done) begin
        stat_t s;
        done_cnt++;
        if (st_q.size() == 0) fail_now("unexpected done", "done pulse with none required");
        else begin
          s = st_q.pop_front();
          check("pid", {60'd0, pid}, {60'd0, s.pid});
          check("err", {60'd0, err & s.mask}, {60'd0, s.err});
          check("ok", {63'd0, ok}, {63'd0, s.ok});
          if (s.tok) begin
            check("addr", {57'd0, addr}, {57'd0, s.addr});
            check("endp", {60'd0, endp}, {60'd0, s.endp});
            check("frame", {53'd0, frame}, {53'd0, s.frame});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_pkt(input int err_at);
    tick();
    rx_active = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < pk_n; i++) begin
      if (i == err_at) begin
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
      end
      send_byte(pk[i]);
    end
    rx_active = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) fail_now("done timeout", "no done within 20 cycles, done required");
    tick();
    check("leftover payload", pay_q.size(), 0);
    check("leftover status", st_q.size(), 0);
  endtask

  function automatic stat_t mk_stat(input logic [3:0] p, input logic [3:0] e, input logic [3:0] m,
                                    input logic o);
    stat_t s;
    s = '0;
    s.pid = p; s.err = e; s.mask = m; s.ok = o;
    return s;
  endfunction

  task automatic check_zero_outputs(input string name);
    check(name, {23'd0, pid, addr, endp, frame, out_data, out_valid, done, ok, err}, 64'd0);
  endtask

  initial begin
    vec_t       vt[10];
    stat_t      s;
    logic [7:0] b2;
    logic [15:0] c;
    int         d0;

    reset = 1'b1; rx_data = 8'h00; rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset state");
    reset = 1'b0;
    repeat (2) tick();

    //            bytes            nb add flip pid  err  nout tok addr  endp frame
    vt[0] = '{64'h10002D,         3, 0,  0,   4'hD, 4'h0, 0,  1,  7'h00, 4'h0, 11'h000};
    vt[1] = '{64'hD2,             1, 0,  0,   4'h2, 4'h0, 0,  0,  7'h00, 4'h0, 11'h000};
    vt[2] = '{64'h00D2,           2, 0,  0,   4'h2, 4'h4, 0,  0,  7'h00, 4'h0, 11'h000};
    vt[3] = '{64'h0000C3,         3, 0,  0,   4'h3, 4'h0, 0,  0,  7'h00, 4'h0, 11'h000};
    vt[4] = '{64'h040302014B,     5, 1,  0,   4'hB, 4'h0, 4,  0,  7'h00, 4'h0, 11'h000};
    vt[5] = '{64'h040302014B,     5, 1,  1,   4'hB, 4'h2, 4,  0,  7'h00, 4'h0, 11'h000};
    vt[6] = '{64'h11002D,         3, 0,  0,   4'hD, 4'h2, 0,  0,  7'h00, 4'h0, 11'h000};
    vt[7] = '{64'h10002C,         3, 0,  0,   4'hC, 4'h1, 0,  0,  7'h00, 4'h0, 11'h000};
    b2 = tok_b2(8'h3A, 3'b101);
    vt[8] = '{{40'd0, b2, 8'h3A, 8'hE1}, 3, 0, 0, 4'h1, 4'h0, 0, 1, 7'h3A, 4'hA, 11'h53A};
    b2 = tok_b2(8'hA3, 3'b101);
    vt[9] = '{{40'd0, b2, 8'hA3, 8'hA5}, 3, 0, 0, 4'h5, 4'h0, 0, 1, 7'h23, 4'hB, 11'h5A3};

    for (int v = 0; v < 10; v++) begin
      pk_n = int'(vt[v].nb);
      for (int i = 0; i < pk_n; i++) pk[i] = vt[v].bytes[i*8 +: 8];
      if (vt[v].add_crc) begin
        c = crc16_bytes(1, pk_n - 1);
        pk[pk_n] = c[15:8];
        pk[pk_n+1] = c[7:0];
        pk_n += 2;
      end
      if (vt[v].flip) pk[2] = pk[2] ^ 8'h01;
      for (int i = 1; i <= int'(vt[v].nout); i++) pay_q.push_back(pk[i]);
      s = mk_stat(vt[v].pid, vt[v].err, 4'hF, vt[v].err == 4'h0);
      s.tok = vt[v].tok; s.addr = vt[v].addr; s.endp = vt[v].endp; s.frame = vt[v].frame;
      st_q.push_back(s);
      d0 = done_cnt;
      send_pkt(-1);
      wait_done(d0);
    end

    // rx_error after three payload bytes: only the first byte has left the buffer.
    pk[0] = 8'h4B;
    for (int i = 1; i <= 5; i++) pk[i] = 8'(i);
    pk_n = 6;
    pay_q.push_back(8'h01);
    st_q.push_back(mk_stat(4'hB, 4'h8, 4'h8, 1'b0));
    d0 = done_cnt;
    send_pkt(4);
    wait_done(d0);

    // One payload byte beyond MAX_DATA.
    pk[0] = 8'h4B;
    for (int i = 1; i <= MAXD + 1; i++) pk[i] = 8'(i);
    pk_n = MAXD + 2;
    c = crc16_bytes(1, pk_n - 1);
    pk[pk_n] = c[15:8];
    pk[pk_n+1] = c[7:0];
    pk_n += 2;
    skip_pay = 1'b1;
    st_q.push_back(mk_stat(4'hB, 4'h4, 4'h4, 1'b0));
    d0 = done_cnt;
    send_pkt(-1);
    wait_done(d0);
    skip_pay = 1'b0;

    // Reset in the middle of a data packet, released while the packet continues.
    d0 = done_cnt;
    tick();
    rx_active = 1'b1;
    repeat (2) tick();
    send_byte(8'h4B);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    tick();
    check_zero_outputs("reset mid-packet");
    reset = 1'b0;
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    rx_active = 1'b0;
    repeat (15) tick();
    check("done after reset", done_cnt, d0);

    pk[0] = 8'hD2;
    pk_n = 1;
    st_q.push_back(mk_stat(4'h2, 4'h0, 4'hF, 1'b1));
    d0 = done_cnt;
    send_pkt(-1);
    wait_done(d0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
